mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS core. Sequences each instruction
//  through fetch/decode/execute/memory/writeback. Drives the datapath muxes,
//  register/memory enables and the 2-bit ALUOp consumed by ALU_Control.
//  Stalls on a single-ready memory handshake and counts retired instructions.
// PARAMETERS
//  CNT_W    32   width of the retired-instruction counter (wraps modulo 2**CNT_W)
// PORTS
//  clk         in   1      rising-edge clock; the single clock domain
//  rst_n       in   1      asynchronous active-low reset
//  opcode      in   6      instr[31:26] taken from the IR; sampled in DECODE only
//  mem_ready   in   1      memory access completes in the current cycle
//  ALUOp       out  2      00 add, 01 sub, 10 use funct; 11 never driven
//  ALUSrcA     out  1      0 = PC, 1 = reg A
//  ALUSrcB     out  2      00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
//  PCSrc       out  2      00 = ALU result, 01 = ALUOut, 10 = jump target
//  IorD        out  1      memory address: 0 = PC, 1 = ALUOut
//  MemRead     out  1      memory read request
//  MemWrite    out  1      memory write request
//  IRWrite     out  1      IR load enable
//  RegDst      out  1      write-register select: 0 = rt, 1 = rd
//  MemtoReg    out  1      write-data select: 0 = ALUOut, 1 = MDR
//  RegWrite    out  1      register file write enable
//  PCWrite     out  1      unconditional PC load
//  Branch      out  1      PC load qualified by ALU zero (datapath ANDs them)
//  illegal_op  out  1      one-cycle pulse: unsupported opcode reached DECODE
//  state_o     out  4      current state encoding, for debug and the bench
//  retired     out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, retired=0, illegal_op=0. Every control output is 0.
//  - Moore decode: outputs depend on state only. Exceptions: IRWrite and PCWrite
//    in FETCH are gated by mem_ready.
//  - States and encodings, with active outputs (any output not listed is 0):
//    IDLE(0): all outputs 0. Next state is FETCH unconditionally, so reset release costs one cycle.
//    FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00,
//      IRWrite=PCWrite=mem_ready. If mem_ready: DECODE, else hold FETCH.
//    DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
//      LW 100011 / SW 101011 -> MEMADR; R 000000 -> EXEC; BEQ 000100 -> BRANCH;
//      ADDI 001000 -> ADDIEX; J 000010 -> JUMP. Any other opcode -> FETCH, and
//      illegal_op=1 on the following cycle only. An illegal op is not counted.
//    MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
//      Opcode is re-read here and must be held stable by the IR.
//    MEMRD(4): IorD=1, MemRead=1. Hold until mem_ready, then MEMWB.
//    MEMWB(5): RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
//    MEMWR(6): IorD=1, MemWrite=1, held asserted until mem_ready, then FETCH.
//    EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
//    ALUWB(8): RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
//    BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
//    ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
//    ADDIWB(11): RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
//    JUMP(12): PCSrc=10, PCWrite=1. Next: FETCH.
//    Encodings 13-15 are unreachable; if entered, all outputs are 0 and next state is FETCH.
//  - Cycle counts with mem_ready tied to 1: R=4, ADDI=4, BEQ=3, J=3, SW=4, LW=5.
//    Each memory wait cycle adds exactly one cycle.
//  - retired increments by 1 on the final cycle of an instruction: leaving MEMWB,
//    ALUWB, BRANCH, ADDIWB or JUMP, or leaving MEMWR with mem_ready=1.
//    It wraps from all-ones to 0.
//  - mem_ready is ignored in every state except FETCH, MEMRD and MEMWR.
//  - Reset mid-instruction: immediate return to IDLE. Partial instructions are not counted.
// STRUCTURE
//  - Shared package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//    OP_ADDI, OP_J), ALUOp codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
//    and the state encodings above. ALU_Control and this block both import it.
//  - Single module: state register plus next-state logic, a combinational output
//    decoder, and the retired counter. No sub-module.
// TESTING (bench holds opcode constant after DECODE, as the IR would)
//  1. Reset: rst_n=0 mid-run -> state_o=0, all outputs 0, retired=0; release ->
//     FETCH one cycle later.
//  2. R-type, mem_ready=1: states 1,2,7,8 -> ALUOp=10 in EXEC, RegWrite=RegDst=1 in ALUWB;
//     retired 0->1.
//  3. LW with mem_ready low 3 cycles in MEMRD: states 1,2,3,4,4,4,4,5; MemRead=IorD=1
//     held throughout; retired increments once.
//  4. SW then BEQ: MemWrite held until mem_ready; BEQ drives ALUOp=01, Branch=1,
//     PCSrc=01; retired +2.
//  5. opcode 6'b111111 -> DECODE->FETCH, illegal_op high exactly 1 cycle, retired unchanged.
//  6. FETCH stall: mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 during the stall,
//     1 on the ready cycle; J then shows PCSrc=10, PCWrite=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALUOp codes, control FSM states.
// Imported by the main control FSM and by ALU_Control.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: Moore control decode per state, retired-instruction counter.
// Latency: 3-5 cycles per instruction with mem_ready high; one extra cycle per memory wait.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; mem_ready ignored elsewhere.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire_now;
    ctrl_t             ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = 1'b0;
        retire_now = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
                illegal_d = !is_legal_op(opcode);
            end
            // Opcode is still held by the IR, so LW/SW split here rather than in DECODE.
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  begin state_d = S_FETCH; retire_now = 1'b1; end
            S_MEMWR:  begin
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
                retire_now = mem_ready;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  begin state_d = S_FETCH; retire_now = 1'b1; end
            S_BRANCH: begin state_d = S_FETCH; retire_now = 1'b1; end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin state_d = S_FETCH; retire_now = 1'b1; end
            S_JUMP:   begin state_d = S_FETCH; retire_now = 1'b1; end
            default:  state_d = S_FETCH;
        endcase
        retired_d = retire_now ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = ALUOP_ADD;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_b = 2'b11;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_SUB;
                ctl.pc_src    = 2'b01;
                ctl.branch    = 1'b1;
            end
            S_ADDIWB: ctl.reg_write = 1'b1;
            S_JUMP: begin
                ctl.pc_src   = 2'b10;
                ctl.pc_write = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    assign ALUOp      = ctl.alu_op;
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign PCSrc      = ctl.pc_src;
    assign IorD       = ctl.iord;
    assign MemRead    = ctl.mem_read;
    assign MemWrite   = ctl.mem_write;
    assign IRWrite    = ctl.ir_write;
    assign RegDst     = ctl.reg_dst;
    assign MemtoReg   = ctl.mem_to_reg;
    assign RegWrite   = ctl.reg_write;
    assign PCWrite    = ctl.pc_write;
    assign Branch     = ctl.branch;
    assign illegal_op = illegal_q;
    assign state_o    = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM; each row is one cycle:
// {opcode, state, mem_ready, illegal_op, retires_this_cycle, control vector}.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [1:0]  ALUOp;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCWrite, Branch;
    logic        illegal_op;
    logic [3:0]  state_o;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int unsigned exp_ret = 0;

    // Control vector bit order:
    // [15:14]ALUOp [13]ALUSrcA [12:11]ALUSrcB [10:9]PCSrc [8]IorD [7]MemRead
    // [6]MemWrite [5]IRWrite [4]RegDst [3]MemtoReg [2]RegWrite [1]PCWrite [0]Branch
    logic [15:0] ctl;
    assign ctl = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, MemRead, MemWrite,
                  IRWrite, RegDst, MemtoReg, RegWrite, PCWrite, Branch};

    mips_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .Branch(Branch), .illegal_op(illegal_op),
        .state_o(state_o), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++; if (ctl !== 16'h0000) begin errors++; $display("FAIL reset_ctl got %h exp 0000", ctl); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal_op); end
        rst_n = 1'b1;
        #1;
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL release_idle got %0d exp 0", state_o); end
    endtask

    task automatic test_rtype();
        logic [28:0] v [4] = '{
            {6'h00, 4'd1, 1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h00, 4'd2, 1'b1, 1'b0, 1'b0, 16'h1800},
            {6'h00, 4'd7, 1'b0, 1'b0, 1'b0, 16'hA000},
            {6'h00, 4'd8, 1'b0, 1'b0, 1'b1, 16'h0014}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL rtype_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL rtype_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (illegal_op !== v[i][17]) begin errors++; $display("FAIL rtype_illegal cyc%0d got %b exp %b", i, illegal_op, v[i][17]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL rtype_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_addi();
        logic [28:0] v [4] = '{
            {6'h08, 4'd1,  1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h08, 4'd2,  1'b0, 1'b0, 1'b0, 16'h1800},
            {6'h08, 4'd10, 1'b0, 1'b0, 1'b0, 16'h3000},
            {6'h08, 4'd11, 1'b0, 1'b0, 1'b1, 16'h0004}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL addi_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL addi_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL addi_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_lw_stall();
        // mem_ready is dropped in DECODE/MEMADR/MEMWB too, where it must be ignored.
        logic [28:0] v [8] = '{
            {6'h23, 4'd1, 1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h23, 4'd2, 1'b0, 1'b0, 1'b0, 16'h1800},
            {6'h23, 4'd3, 1'b0, 1'b0, 1'b0, 16'h3000},
            {6'h23, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0180},
            {6'h23, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0180},
            {6'h23, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0180},
            {6'h23, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0180},
            {6'h23, 4'd5, 1'b0, 1'b0, 1'b1, 16'h000C}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL lw_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL lw_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL lw_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_sw_beq();
        logic [28:0] v [8] = '{
            {6'h2B, 4'd1, 1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h2B, 4'd2, 1'b1, 1'b0, 1'b0, 16'h1800},
            {6'h2B, 4'd3, 1'b1, 1'b0, 1'b0, 16'h3000},
            {6'h2B, 4'd6, 1'b0, 1'b0, 1'b0, 16'h0140},
            {6'h2B, 4'd6, 1'b1, 1'b0, 1'b1, 16'h0140},
            {6'h04, 4'd1, 1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h04, 4'd2, 1'b1, 1'b0, 1'b0, 16'h1800},
            {6'h04, 4'd9, 1'b0, 1'b0, 1'b1, 16'h6201}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL swbeq_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL swbeq_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL swbeq_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_illegal();
        // FETCH is stalled after the bad decode so the opcode is not decoded twice.
        logic [28:0] v [4] = '{
            {6'h3F, 4'd1, 1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h3F, 4'd2, 1'b1, 1'b0, 1'b0, 16'h1800},
            {6'h3F, 4'd1, 1'b0, 1'b1, 1'b0, 16'h0880},
            {6'h3F, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0880}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL illegal_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL illegal_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (illegal_op !== v[i][17]) begin errors++; $display("FAIL illegal_pulse cyc%0d got %b exp %b", i, illegal_op, v[i][17]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL illegal_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_fetch_stall_jump();
        logic [28:0] v [6] = '{
            {6'h02, 4'd1,  1'b0, 1'b0, 1'b0, 16'h0880},
            {6'h02, 4'd1,  1'b0, 1'b0, 1'b0, 16'h0880},
            {6'h02, 4'd1,  1'b1, 1'b0, 1'b0, 16'h08A2},
            {6'h02, 4'd2,  1'b1, 1'b0, 1'b0, 16'h1800},
            {6'h02, 4'd12, 1'b0, 1'b0, 1'b1, 16'h0402},
            {6'h02, 4'd1,  1'b0, 1'b0, 1'b0, 16'h0880}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); opcode = v[i][28:23]; mem_ready = v[i][18]; #1;
            checks++; if (state_o !== v[i][22:19]) begin errors++; $display("FAIL jump_state cyc%0d got %0d exp %0d", i, state_o, v[i][22:19]); end
            checks++; if (ctl !== v[i][15:0]) begin errors++; $display("FAIL jump_ctl cyc%0d got %h exp %h", i, ctl, v[i][15:0]); end
            checks++; if (retired !== exp_ret) begin errors++; $display("FAIL jump_retired cyc%0d got %0d exp %0d", i, retired, exp_ret); end
            if (v[i][16]) exp_ret++;
        end
    endtask

    task automatic test_reset_midrun();
        opcode = 6'b000000;
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL midrun_pre_state got %0d exp 1", state_o); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'd2) begin errors++; $display("FAIL midrun_decode got %0d exp 2", state_o); end
        checks++; if (retired !== 32'd6) begin errors++; $display("FAIL midrun_pre_retired got %0d exp 6", retired); end
        rst_n = 1'b0; #1;
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL midrun_state got %0d exp 0", state_o); end
        checks++; if (ctl !== 16'h0000) begin errors++; $display("FAIL midrun_ctl got %h exp 0000", ctl); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL midrun_retired got %0d exp 0", retired); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL midrun_idle got %0d exp 0", state_o); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL midrun_fetch got %0d exp 1", state_o); end
        checks++; if (ctl !== 16'h08A2) begin errors++; $display("FAIL midrun_fetch_ctl got %h exp 08a2", ctl); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_stall();
        test_sw_beq();
        test_illegal();
        test_fetch_stall_jump();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
